capture_engine_v2: RTL and testbench

//  Parametrised next-generation logic-analyser capture engine. Samples PROBE_W probe lines on sample_strobe and holds
//  a runtime-programmable pre-trigger history in an on-chip ring buffer. It detects edge/level triggers on a selected

---
 rtl/capture_engine_v2_if.sv | 24 ++
 rtl/capture_engine_v2.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_capture_engine_v2.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/capture_engine_v2_if.sv
// SDRAM write port of the capture engine: request/ready handshake carrying address and sample data.
interface capture_engine_v2_if #(
    parameter int PROBE_W = 8,
    parameter int ADDR_W  = 13
) ();
    logic               sdram_wr_req;
    logic [ADDR_W-1:0]  sdram_wr_addr;
    logic [PROBE_W-1:0] sdram_wr_data;
    logic               sdram_wr_ready;

    modport master (
        output sdram_wr_req,
        output sdram_wr_addr,
        output sdram_wr_data,
        input  sdram_wr_ready
    );

    modport slave (
        input  sdram_wr_req,
        input  sdram_wr_addr,
        input  sdram_wr_data,
        output sdram_wr_ready
    );
endinterface

// File: rtl/capture_engine_v2.sv
// Logic-analyser capture engine: pre-trigger ring buffer, edge/level trigger, streaming of pre+post samples to SDRAM.
// Optional build macro CAPTURE_PATTERN_TRIG_EN turns trig_mode 11 into a masked pattern match (adds trig_pattern/trig_mask).
module capture_engine_v2 #(
    parameter int PROBE_W   = 8,
    parameter int ADDR_W    = 13,
    parameter int PRE_DEPTH = 32,
    parameter int CNT_W     = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         arm,
    input  logic                         soft_reset,
    input  logic [PROBE_W-1:0]           probe_input,
    input  logic                         sample_strobe,
    input  logic [$clog2(PROBE_W)-1:0]   trig_ch,
    input  logic [1:0]                   trig_mode,
    input  logic [$clog2(PRE_DEPTH)-1:0] pre_count,
    input  logic [CNT_W-1:0]             total_count,
`ifdef CAPTURE_PATTERN_TRIG_EN
    input  logic [PROBE_W-1:0]           trig_pattern,
    input  logic [PROBE_W-1:0]           trig_mask,
`endif
    output logic                         armed,
    output logic                         triggered,
    output logic                         captured,
    output logic                         overflow,
    output logic [CNT_W-1:0]             sample_count,
    output logic                         pause_refresh,
    capture_engine_v2_if.master          wr
);
    localparam int CH_W = $clog2(PROBE_W);
    localparam int PW   = $clog2(PRE_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_TRIG  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_r;
    logic [CH_W-1:0]    trig_ch_r;
    logic [1:0]         trig_mode_r;
    logic [PW-1:0]      pre_eff_r;
    logic [CNT_W-1:0]   tot_eff_r;
    logic [CNT_W-1:0]   post_tot_r;
    logic [CNT_W-1:0]   pushed_post_r;
    logic [CNT_W-1:0]   drop_cnt_r;
    logic [CNT_W-1:0]   sample_count_r;
    logic [PW-1:0]      wr_ptr_r;
    logic [PW-1:0]      rd_ptr_r;
    logic [PW:0]        occ_r;
    logic               prev_bit_r;
    logic               prev_valid_r;
    logic               armed_r;
    logic               triggered_r;
    logic               captured_r;
    logic               overflow_r;
    logic               pause_r;
    logic               req_r;
    logic               from_ring_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [PROBE_W-1:0] data_r;
    logic [PROBE_W-1:0] ring_r [PRE_DEPTH];
`ifdef CAPTURE_PATTERN_TRIG_EN
    logic [PROBE_W-1:0] trig_pattern_r;
    logic [PROBE_W-1:0] trig_mask_r;
`endif

    logic               cur_bit_s;
    logic               cond_s;
    logic               trig_hit_s;
    logic               ring_full_s;
    logic               post_room_s;
    logic               push_s;
    logic               drop_s;
    logic               accept_s;
    logic               pop_s;
    logic               ring_we_s;
    logic [CNT_W-1:0]   tot_arm_s;
    logic [PW-1:0]      pre_arm_s;
    logic [CNT_W-1:0]   post_arm_s;
    logic [CNT_W-1:0]   sc_next_s;

    assign armed          = armed_r;
    assign triggered      = triggered_r;
    assign captured       = captured_r;
    assign overflow       = overflow_r;
    assign sample_count   = sample_count_r;
    assign pause_refresh  = pause_r;
    assign wr.sdram_wr_req  = req_r;
    assign wr.sdram_wr_addr = addr_r;
    assign wr.sdram_wr_data = data_r;

    // Trigger qualification, ring push/drop/pop decisions and arm-time effective counts.
    always_comb begin
        cur_bit_s = probe_input[trig_ch_r];
        cond_s    = 1'b0;
        case (trig_mode_r)
            2'b00:   cond_s = prev_valid_r && !prev_bit_r && cur_bit_s;
            2'b01:   cond_s = prev_valid_r && prev_bit_r && !cur_bit_s;
            2'b10:   cond_s = prev_valid_r && (prev_bit_r != cur_bit_s);
`ifdef CAPTURE_PATTERN_TRIG_EN
            2'b11:   cond_s = ((probe_input & trig_mask_r) == (trig_pattern_r & trig_mask_r));
`else
            2'b11:   cond_s = cur_bit_s;
`endif
            default: cond_s = 1'b0;
        endcase
        // Only fire once the requested pre-trigger history is in the ring.
        trig_hit_s  = (state_r == ST_ARMED) && sample_strobe &&
                      (occ_r == {1'b0, pre_eff_r}) && cond_s;
        ring_full_s = (occ_r == (PW+1)'(PRE_DEPTH));
        post_room_s = (pushed_post_r < post_tot_r);
        push_s      = (state_r == ST_TRIG) && sample_strobe && post_room_s && !ring_full_s;
        drop_s      = (state_r == ST_TRIG) && sample_strobe && post_room_s && ring_full_s;
        accept_s    = (state_r == ST_TRIG) && req_r && wr.sdram_wr_ready;
        pop_s       = accept_s && from_ring_r;
        ring_we_s   = ((state_r == ST_ARMED) && sample_strobe) || push_s;
        sc_next_s   = sample_count_r + CNT_W'(1);

        if (total_count == {CNT_W{1'b0}}) begin
            tot_arm_s = CNT_W'(1);
        end else begin
            tot_arm_s = total_count;
        end
        if (CNT_W'(pre_count) > (tot_arm_s - CNT_W'(1))) begin
            pre_arm_s = PW'(tot_arm_s - CNT_W'(1));
        end else begin
            pre_arm_s = pre_count;
        end
        post_arm_s = tot_arm_s - CNT_W'(pre_arm_s);
    end

    // Ring storage; contents need no reset because pointers and occupancy gate every read.
    always_ff @(posedge clk) begin
        if (ring_we_s) begin
            ring_r[wr_ptr_r] <= probe_input;
        end
    end

    // Capture FSM with ring bookkeeping, write-port sequencing and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            trig_ch_r      <= {CH_W{1'b0}};
            trig_mode_r    <= 2'b00;
            pre_eff_r      <= {PW{1'b0}};
            tot_eff_r      <= {CNT_W{1'b0}};
            post_tot_r     <= {CNT_W{1'b0}};
            pushed_post_r  <= {CNT_W{1'b0}};
            drop_cnt_r     <= {CNT_W{1'b0}};
            sample_count_r <= {CNT_W{1'b0}};
            wr_ptr_r       <= {PW{1'b0}};
            rd_ptr_r       <= {PW{1'b0}};
            occ_r          <= {(PW+1){1'b0}};
            prev_bit_r     <= 1'b0;
            prev_valid_r   <= 1'b0;
            armed_r        <= 1'b0;
            triggered_r    <= 1'b0;
            captured_r     <= 1'b0;
            overflow_r     <= 1'b0;
            pause_r        <= 1'b0;
            req_r          <= 1'b0;
            from_ring_r    <= 1'b0;
            addr_r         <= {ADDR_W{1'b0}};
            data_r         <= {PROBE_W{1'b0}};
`ifdef CAPTURE_PATTERN_TRIG_EN
            trig_pattern_r <= {PROBE_W{1'b0}};
            trig_mask_r    <= {PROBE_W{1'b0}};
`endif
        end else if (soft_reset) begin
            state_r        <= ST_IDLE;
            pushed_post_r  <= {CNT_W{1'b0}};
            drop_cnt_r     <= {CNT_W{1'b0}};
            sample_count_r <= {CNT_W{1'b0}};
            wr_ptr_r       <= {PW{1'b0}};
            rd_ptr_r       <= {PW{1'b0}};
            occ_r          <= {(PW+1){1'b0}};
            prev_valid_r   <= 1'b0;
            armed_r        <= 1'b0;
            triggered_r    <= 1'b0;
            captured_r     <= 1'b0;
            overflow_r     <= 1'b0;
            pause_r        <= 1'b0;
            req_r          <= 1'b0;
            from_ring_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_r        <= ST_ARMED;
                        trig_ch_r      <= trig_ch;
                        trig_mode_r    <= trig_mode;
                        pre_eff_r      <= pre_arm_s;
                        tot_eff_r      <= tot_arm_s;
                        post_tot_r     <= post_arm_s;
                        pushed_post_r  <= {CNT_W{1'b0}};
                        drop_cnt_r     <= {CNT_W{1'b0}};
                        sample_count_r <= {CNT_W{1'b0}};
                        wr_ptr_r       <= {PW{1'b0}};
                        rd_ptr_r       <= {PW{1'b0}};
                        occ_r          <= {(PW+1){1'b0}};
                        prev_valid_r   <= 1'b0;
                        armed_r        <= 1'b1;
                        captured_r     <= 1'b0;
                        overflow_r     <= 1'b0;
                        pause_r        <= 1'b1;
                        req_r          <= 1'b0;
`ifdef CAPTURE_PATTERN_TRIG_EN
                        trig_pattern_r <= trig_pattern;
                        trig_mask_r    <= trig_mask;
`endif
                    end
                end
                ST_ARMED: begin
                    if (sample_strobe) begin
                        wr_ptr_r     <= wr_ptr_r + PW'(1);
                        prev_bit_r   <= cur_bit_s;
                        prev_valid_r <= 1'b1;
                        if (trig_hit_s) begin
                            occ_r         <= occ_r + (PW+1)'(1);
                            pushed_post_r <= CNT_W'(1);
                            state_r       <= ST_TRIG;
                            armed_r       <= 1'b0;
                            triggered_r   <= 1'b1;
                        end else if (occ_r == {1'b0, pre_eff_r}) begin
                            // History already full: the oldest entry slides out.
                            rd_ptr_r <= rd_ptr_r + PW'(1);
                        end else begin
                            occ_r <= occ_r + (PW+1)'(1);
                        end
                    end
                end
                ST_TRIG: begin
                    if (push_s) begin
                        wr_ptr_r <= wr_ptr_r + PW'(1);
                    end
                    if (pop_s) begin
                        rd_ptr_r <= rd_ptr_r + PW'(1);
                    end
                    occ_r <= occ_r + {{PW{1'b0}}, push_s} - {{PW{1'b0}}, pop_s};
                    if (push_s || drop_s) begin
                        pushed_post_r <= pushed_post_r + CNT_W'(1);
                    end
                    if (drop_s) begin
                        overflow_r <= 1'b1;
                    end
                    // Dropped samples still own an address; they are written later as zero fillers.
                    drop_cnt_r <= drop_cnt_r + {{(CNT_W-1){1'b0}}, drop_s}
                                  - {{(CNT_W-1){1'b0}}, (accept_s && !from_ring_r)};
                    if (accept_s) begin
                        req_r          <= 1'b0;
                        sample_count_r <= sc_next_s;
                        if (sc_next_s == tot_eff_r) begin
                            state_r     <= ST_DONE;
                            triggered_r <= 1'b0;
                            pause_r     <= 1'b0;
                            captured_r  <= 1'b1;
                        end
                    end else if (!req_r) begin
                        if (occ_r != {(PW+1){1'b0}}) begin
                            req_r       <= 1'b1;
                            addr_r      <= ADDR_W'(sample_count_r);
                            data_r      <= ring_r[rd_ptr_r];
                            from_ring_r <= 1'b1;
                        end else if (drop_cnt_r != {CNT_W{1'b0}}) begin
                            req_r       <= 1'b1;
                            addr_r      <= ADDR_W'(sample_count_r);
                            data_r      <= {PROBE_W{1'b0}};
                            from_ring_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_capture_engine_v2.sv
// Directed/randomised bench for capture_engine_v2: the expected SDRAM image is a contiguous slice of the strobed sample stream.
`timescale 1ns/1ps
module tb_capture_engine_v2;
    localparam int PROBE_W   = 8;
    localparam int ADDR_W    = 13;
    localparam int PRE_DEPTH = 32;
    localparam int CNT_W     = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm = 1'b0;
    logic        soft_reset = 1'b0;
    logic        sample_strobe = 1'b0;
    logic [7:0]  probe_input = 8'h00;
    logic [2:0]  trig_ch = 3'd0;
    logic [1:0]  trig_mode = 2'b00;
    logic [4:0]  pre_count = 5'd0;
    logic [11:0] total_count = 12'd0;
    logic        armed, triggered, captured, overflow, pause_refresh;
    logic [11:0] sample_count;
`ifdef CAPTURE_PATTERN_TRIG_EN
    logic [7:0]  trig_pattern = 8'h00;
    logic [7:0]  trig_mask = 8'h00;
`endif

    capture_engine_v2_if #(.PROBE_W(PROBE_W), .ADDR_W(ADDR_W)) bus ();

    capture_engine_v2 #(
        .PROBE_W(PROBE_W), .ADDR_W(ADDR_W), .PRE_DEPTH(PRE_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .soft_reset(soft_reset),
        .probe_input(probe_input), .sample_strobe(sample_strobe),
        .trig_ch(trig_ch), .trig_mode(trig_mode), .pre_count(pre_count),
        .total_count(total_count),
`ifdef CAPTURE_PATTERN_TRIG_EN
        .trig_pattern(trig_pattern), .trig_mask(trig_mask),
`endif
        .armed(armed), .triggered(triggered), .captured(captured),
        .overflow(overflow), .sample_count(sample_count),
        .pause_refresh(pause_refresh), .wr(bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Write-port monitor: logs every accepted write and counts addr/data changes while a request is stalled.
    logic [12:0] wq[$];
    logic [7:0]  dq[$];
    int          stab_err = 0;
    logic        pend = 1'b0;
    logic [12:0] p_addr = 13'd0;
    logic [7:0]  p_data = 8'h00;
    always @(posedge clk) begin
        if (bus.sdram_wr_req && bus.sdram_wr_ready) begin
            wq.push_back(bus.sdram_wr_addr);
            dq.push_back(bus.sdram_wr_data);
        end
        if (pend && bus.sdram_wr_req && (bus.sdram_wr_addr != p_addr || bus.sdram_wr_data != p_data))
            stab_err <= stab_err + 1;
        pend   <= bus.sdram_wr_req && !bus.sdram_wr_ready;
        p_addr <= bus.sdram_wr_addr;
        p_data <= bus.sdram_wr_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference trigger search: first sample at index >= pre_eff meeting the mode's rule.
    function automatic int find_trig(input logic [7:0] h[$], input int ch, input int mode, input int pre_e);
        for (int i = pre_e; i < h.size(); i++) begin
            logic c, p;
            c = h[i][ch];
            p = (i > 0) ? h[i-1][ch] : 1'b0;
            if (mode == 0 && i > 0 && !p && c) return i;
            if (mode == 1 && i > 0 && p && !c) return i;
            if (mode == 2 && i > 0 && p != c) return i;
            if (mode == 3 && c) return i;
        end
        return -1;
    endfunction

    task automatic run_capture(input string tag, input int ch, input int mode, input int pre,
                               input int total, input int ready_pct, input int gap, input int trig_at,
                               input bit rand_other, input int stall, input bit exp_ovf);
        logic [7:0] hist[$];
        logic [7:0] v;
        logic       idle;
        int cyc, s, since_trig, tot_e, pre_e, tidx, n_chk, wbase, stab0, bad_addr, bad_data;
        idle = (mode == 1);
        tot_e = (total == 0) ? 1 : total;
        pre_e = pre;
        if (pre_e > PRE_DEPTH - 1) pre_e = PRE_DEPTH - 1;
        if (pre_e > tot_e - 1) pre_e = tot_e - 1;
        trig_ch = 3'(ch); trig_mode = 2'(mode); pre_count = 5'(pre); total_count = 12'(total);
`ifdef CAPTURE_PATTERN_TRIG_EN
        trig_mask = 8'h01 << ch; trig_pattern = 8'h01 << ch;
`endif
        wbase = wq.size(); stab0 = stab_err;
        arm = 1'b1; tick(); arm = 1'b0;
        chk({tag, "_armed"}, {31'd0, armed}, 32'd1);
        cyc = 0; s = 0; since_trig = 0;
        while (captured !== 1'b1 && cyc < 20000) begin
            if (cyc % gap == 0) begin
                if (s <= trig_at) begin
                    v = rand_other ? 8'($urandom) : 8'h00;
                    v[ch] = (s < trig_at) ? idle : ~idle;
                end else begin
                    v = 8'($urandom);
                end
                hist.push_back(v);
                probe_input = v; sample_strobe = 1'b1; s++;
                if (triggered === 1'b1) since_trig++;
            end else begin
                sample_strobe = 1'b0;
            end
            if (since_trig > 0 && since_trig <= stall) bus.sdram_wr_ready = 1'b0;
            else bus.sdram_wr_ready = ($urandom_range(99) < 32'(ready_pct));
            tick(); cyc++;
        end
        sample_strobe = 1'b0; bus.sdram_wr_ready = 1'b0;
        tick();
        chk({tag, "_captured"}, {31'd0, captured}, 32'd1);
        chk({tag, "_triggered"}, {31'd0, triggered}, 32'd0);
        chk({tag, "_pause"}, {31'd0, pause_refresh}, 32'd0);
        chk({tag, "_count"}, {20'd0, sample_count}, 32'(tot_e));
        chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
        chk({tag, "_nwrites"}, 32'(wq.size() - wbase), 32'(tot_e));
        bad_addr = 0;
        for (int k = wbase; k < wq.size(); k++)
            if (wq[k] != 13'(k - wbase)) bad_addr++;
        chk({tag, "_addr_contig"}, 32'(bad_addr), 32'd0);
        tidx = find_trig(hist, ch, mode, pre_e);
        chk({tag, "_model_trig"}, {31'd0, (tidx >= 0)}, 32'd1);
        n_chk = exp_ovf ? PRE_DEPTH : tot_e;
        bad_data = 0;
        for (int k = 0; k < n_chk && (wbase + k) < wq.size() && tidx >= 0; k++) begin
            int hi;
            hi = tidx - pre_e + k;
            if (hi >= hist.size() || dq[wbase + k] !== hist[hi]) bad_data++;
        end
        chk({tag, "_data"}, 32'(bad_data), 32'd0);
        if (tidx >= 0 && (wbase + pre_e) < wq.size())
            chk({tag, "_trig_word"}, {24'd0, dq[wbase + pre_e]}, {24'd0, hist[tidx]});
        chk({tag, "_stable"}, 32'(stab_err - stab0), 32'd0);
    endtask

    initial begin
        int cyc, s;
        bus.sdram_wr_ready = 1'b0;
        // Reset state
        rst_n = 1'b0; tick(); tick(); tick();
        chk("rst_armed", {31'd0, armed}, 32'd0);
        chk("rst_triggered", {31'd0, triggered}, 32'd0);
        chk("rst_captured", {31'd0, captured}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_count", {20'd0, sample_count}, 32'd0);
        chk("rst_pause", {31'd0, pause_refresh}, 32'd0);
        chk("rst_req", {31'd0, bus.sdram_wr_req}, 32'd0);
        rst_n = 1'b1; tick();
        pre_count = 5'd2; total_count = 12'd10;
        arm = 1'b1; tick(); arm = 1'b0; tick();
        chk("arm_armed", {31'd0, armed}, 32'd1);
        chk("arm_pause", {31'd0, pause_refresh}, 32'd1);
        chk("arm_triggered", {31'd0, triggered}, 32'd0);
        chk("arm_captured", {31'd0, captured}, 32'd0);
        soft_reset = 1'b1; tick(); soft_reset = 1'b0;
        chk("srst_idle_armed", {31'd0, armed}, 32'd0);
        chk("srst_idle_pause", {31'd0, pause_refresh}, 32'd0);

        run_capture("rise", 0, 0, 2, 38, 100, 4, 5, 1'b0, 0, 1'b0);
        run_capture("fall", 5, 1, 2, 38, 100, 4, 5, 1'b0, 0, 1'b0);
        run_capture("rnd", 3, 0, 13, 266, 50, 8, 20, 1'b1, 0, 1'b0);
        run_capture("ovf", 6, 0, 13, 266, 100, 4, 20, 1'b1, 40, 1'b1);
        run_capture("tot0", 2, 2, 0, 0, 70, 3, 4, 1'b1, 0, 1'b0);
        run_capture("lvl", 7, 3, 5, 3, 60, 3, 6, 1'b1, 0, 1'b0);
        run_capture("pmax", 4, 1, 31, 40, 100, 6, 35, 1'b1, 0, 1'b0);

        // Abort a running capture while a write is stalled, then re-arm
        trig_ch = 3'd1; trig_mode = 2'b00; pre_count = 5'd4; total_count = 12'd100;
        bus.sdram_wr_ready = 1'b0;
        arm = 1'b1; tick(); arm = 1'b0;
        cyc = 0; s = 0;
        while (bus.sdram_wr_req !== 1'b1 && cyc < 400) begin
            if (cyc % 2 == 0) begin
                probe_input = (s < 6) ? 8'h00 : 8'h02; sample_strobe = 1'b1; s++;
            end else begin
                sample_strobe = 1'b0;
            end
            tick(); cyc++;
        end
        sample_strobe = 1'b0;
        chk("sr_req_pending", {31'd0, bus.sdram_wr_req}, 32'd1);
        chk("sr_triggered_before", {31'd0, triggered}, 32'd1);
        soft_reset = 1'b1; tick(); soft_reset = 1'b0;
        chk("sr_req", {31'd0, bus.sdram_wr_req}, 32'd0);
        chk("sr_armed", {31'd0, armed}, 32'd0);
        chk("sr_triggered", {31'd0, triggered}, 32'd0);
        chk("sr_captured", {31'd0, captured}, 32'd0);
        chk("sr_count", {20'd0, sample_count}, 32'd0);
        chk("sr_pause", {31'd0, pause_refresh}, 32'd0);
        tick();
        run_capture("rearm", 1, 0, 4, 60, 80, 4, 8, 1'b1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
